data_memory_bytelane: RTL and testbench
=======================================

Name: data_memory_bytelane

Overview:
- Parametrised successor to the single-cycle datapath's word-only data memory.
- Adds byte/halfword/word loads and stores with sign or zero extension, and a parametrised base address and depth.
- Detects misaligned and out-of-range accesses, and records the first faulting address.
- Replaces the instant clear with a sequential one-word-per-cycle sweep that reports busy.
- Sits between the ALU result/register-file rt path and the write-back mux.

Parameters:
- BASE_ADDR, 32'h10010000, byte address of word 0.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096.
- IDX_W, log2(DEPTH_WORDS), word-index width (derived localparam, not overridable).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset; also starts the memory sweep.
- address  in  32  byte address.
- write  in  1  store request this cycle.
- read  in  1  load request this cycle; only used for fault qualification.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault).
- unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- write_data  in  32  store data; bytes taken from the low bits.
- read_data  out  32  combinational load result.
- busy  out  1  high while the clear sweep runs.
- fault  out  1  combinational: current access (read|write) is misaligned, out of range or reserved-size.
- fault_valid  out  1  sticky: a fault has occurred since the last clear.
- fault_addr  out  32  address of the first fault since the last clear.

Behaviour:
- Range check: in_range = address >= BASE_ADDR and address < BASE_ADDR + 4*DEPTH_WORDS.
- Word index: idx = (address - BASE_ADDR) >> 2, truncated to IDX_W.
- Byte lane: lane = address[1:0].
- Alignment: half requires address[0] = 0; word requires address[1:0] = 0.
- fault = (read|write) & (!in_range | misaligned | size==11). fault is 0 while busy.
- Loads are combinational, zero-latency, for single-cycle datapath use.
  - Word: returns the addressed word.
  - Byte: returns the selected lane; byte 0 is bits [7:0] (little-endian lanes).
  - Half: returns the selected half; lane 0 is [15:0], lane 2 is [31:16].
  - Sub-word results are extended per unsigned_ld.
  - read_data = 0 if fault, busy, or !in_range.
- Stores commit on the rising edge when write & !fault & !busy.
  - Byte enables: byte -> 1 lane; half -> 2 lanes; word -> all 4.
  - Unselected bytes of the word are preserved.
  - A same-cycle load sees the old contents; the new value is visible the next cycle.
- Clear sweep, FSM states IDLE and SWEEP:
  - clear=1 in any state (mid-sweep included): next state SWEEP, sweep pointer = 0, fault_valid=0, fault_addr=0.
  - SWEEP, clear=0: write 0 to word[ptr], ptr++. When ptr = DEPTH_WORDS-1 is written, go to IDLE.
  - busy = (state==SWEEP) | clear.
  - Sweep length after clear deasserts: DEPTH_WORDS cycles (256 by default). busy falls on the edge that writes the last word.
  - During busy, stores are ignored and loads return 0.
- Power-up: memory contents are undefined until the first clear; the bench must apply clear before use.
- Fault capture: on a rising edge with fault=1 and fault_valid=0, set fault_valid=1 and latch fault_addr=address. Later faults do not overwrite.
- Reset values, asserted during clear and held until the state first changes afterwards: fault_valid=0, fault_addr=0, busy=1. read_data=0 and fault=0 while busy.
- Each successful store prints "M[addr] = data" with byte mask (simulation only).

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - default BASE_ADDR;
  - the state enum {IDLE, SWEEP}.
- One sub-module, dmem_lane_align (combinational):
  - given size, lane, unsigned_ld, write_data and the stored word, produces byte-enable[3:0], the shifted store word and the extended load word;
  - reused by the future instruction-side cache.

Test Plan:
- Clear sweep: pulse clear 1 cycle -> busy high for 256 cycles then low. Word read at 0x10010000 and 0x100103FC returns 0. Store during busy leaves memory unchanged.
- Word then byte store: store word 0x11223344 at 0x10010010, then store byte 0xAB at 0x10010011 -> load word at 0x10010010 returns 0x1122AB44.
- Signed/unsigned loads with word 0x80FF7F01 at 0x10010020:
  - byte @+1 signed = 0xFFFFFF7F? No: lane 1 is 0x7F, so signed = 0x0000007F.
  - byte @+2 signed = 0xFFFFFFFF.
  - byte @+2 unsigned = 0x000000FF.
  - half @+2 signed = 0xFFFF80FF.
- Misalignment and first-fault capture:
  - word store at 0x10010002 -> fault=1, no memory change, fault_valid=1, fault_addr=0x10010002;
  - then read at 0x0FFFFFFC -> fault=1, fault_addr unchanged.
- Range boundary:
  - store word 0xDEADBEEF at 0x100103FC succeeds, read back matches;
  - access at 0x10010400 -> fault=1, read_data=0.
- Clear mid-sweep:
  - assert clear at sweep cycle 100 -> pointer restarts; busy stays high for another full 256 cycles;
  - fault_valid returns to 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
// Holds the access-size encodings, the default base address and the
// clear-sweep state type used by the memory and its lane aligner.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Data-memory access bus.
// master: drives address, write, read, size, unsigned_ld, write_data;
//         receives read_data, busy, fault, fault_valid, fault_addr.
// slave : the memory side, directions reversed.
interface dmem_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;
  logic        fault;
  logic        fault_valid;
  logic [31:0] fault_addr;

  modport master (
    output address, write, read, size, unsigned_ld, write_data,
    input  read_data, busy, fault, fault_valid, fault_addr
  );

  modport slave (
    input  address, write, read, size, unsigned_ld, write_data,
    output read_data, busy, fault, fault_valid, fault_addr
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for sub-word loads and stores.
// Ports:
//   size        in  access size (byte/half/word/reserved)
//   lane        in  address[1:0]
//   unsigned_ld in  1 = zero-extend sub-word loads, 0 = sign-extend
//   write_data  in  store data, sub-word data in the low bits
//   stored_word in  current contents of the addressed word
//   byte_en     out byte write enables, bit i covers bits [8i+7:8i]
//   store_word  out store data replicated onto every lane
//   load_word   out selected and extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  input  logic [31:0] write_data,
  input  logic [31:0] stored_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Little-endian lanes: lane 0 is bits [7:0]; half lane 2 is bits [31:16].
  assign sel_byte = stored_word[{lane, 3'b000} +: 8];
  assign sel_half = lane[1] ? stored_word[31:16] : stored_word[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    store_word = write_data;
    load_word  = '0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{write_data[7:0]}};
        load_word  = unsigned_ld ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
        load_word  = unsigned_ld ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        store_word = write_data;
        load_word  = stored_word;
      end
      default: begin
        // Reserved size: no enables and no load data; the top flags it as a fault.
        byte_en    = 4'b0000;
        load_word  = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory for the single-cycle datapath.
// Combinational loads, byte/half/word stores, range and alignment fault
// detection with first-fault capture, and a one-word-per-cycle clear sweep.
// Ports:
//   clock  in  rising-edge clock
//   clear  in  synchronous active-high reset; (re)starts the clear sweep
//   bus    slave side of dmem_if (address, write, read, size, unsigned_ld,
//          write_data in; read_data, busy, fault, fault_valid, fault_addr out)
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic   clock,
  input  logic   clear,
  dmem_if.slave  bus
);

  localparam int unsigned      IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      RANGE_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_PTR    = IDX_W'(DEPTH_WORDS - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   sweep_ptr_reg;
  logic               fault_valid_reg;
  logic [31:0]        fault_addr_reg;

  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               misaligned;
  logic               fault;
  logic               busy;
  logic               sweep_we;
  logic               store_we;
  logic [31:0]        stored_word;
  logic [3:0]         byte_en;
  logic [31:0]        store_word;
  logic [31:0]        load_word;

  // Addresses below the base wrap to a huge offset, so one unsigned compare
  // covers both bounds as long as the window itself does not wrap past 2^32.
  assign offset     = bus.address - BASE_ADDR;
  assign in_range   = offset < RANGE_BYTES;
  assign idx        = offset[IDX_W+1:2];
  assign misaligned = ((bus.size == SZ_HALF) && bus.address[0]) ||
                      ((bus.size == SZ_WORD) && (bus.address[1:0] != 2'b00));

  assign busy     = (state_reg == SWEEP) || clear;
  assign fault    = (bus.read || bus.write) && !busy &&
                    (!in_range || misaligned || (bus.size == SZ_RSVD));
  assign sweep_we = (state_reg == SWEEP) && !clear;
  assign store_we = bus.write && !fault && !busy;

  dmem_lane_align u_align (
    .size        (bus.size),
    .lane        (bus.address[1:0]),
    .unsigned_ld (bus.unsigned_ld),
    .write_data  (bus.write_data),
    .stored_word (stored_word),
    .byte_en     (byte_en),
    .store_word  (store_word),
    .load_word   (load_word)
  );

  // One narrow array per byte lane so each lane has its own write enable
  // and unselected bytes of a word are left untouched.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
      if (sweep_we) begin
        mem[sweep_ptr_reg] <= 8'h00;
      end else if (store_we && byte_en[gi]) begin
        mem[idx] <= store_word[8*gi +: 8];
      end
    end

    assign stored_word[8*gi +: 8] = mem[idx];
  end

  // Sweep FSM plus sticky first-fault capture.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg       <= SWEEP;
      sweep_ptr_reg   <= '0;
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
    end else begin
      if (state_reg == SWEEP) begin
        sweep_ptr_reg <= sweep_ptr_reg + 1'b1;
        if (sweep_ptr_reg == LAST_PTR) begin
          state_reg <= IDLE;
        end
      end
      if (fault && !fault_valid_reg) begin
        fault_valid_reg <= 1'b1;
        fault_addr_reg  <= bus.address;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.fault       = fault;
  assign bus.fault_valid = fault_valid_reg;
  assign bus.fault_addr  = fault_addr_reg;
  assign bus.read_data   = (fault || busy || !in_range) ? 32'h0 : load_word;

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;
  import dmem_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  dmem_if bus ();

  data_memory_bytelane #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (256)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        flt;
    logic        fv;
    logic [31:0] fa;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] sz,
                       input logic us, input logic [31:0] a, input logic [31:0] wd);
    bus.write       = w;
    bus.read        = r;
    bus.size        = sz;
    bus.unsigned_ld = us;
    bus.address     = a;
    bus.write_data  = wd;
  endtask

  task automatic push_exp(input string n, input logic [31:0] rd, input logic flt,
                          input logic fv, input logic [31:0] fa, input logic bsy);
    exp_t e;
    e.name = n; e.rd = rd; e.flt = flt; e.fv = fv; e.fa = fa; e.bsy = bsy;
    sb.push_back(e);
  endtask

  // One access: drive, record the expected response, advance one cycle.
  task automatic txn(input string n, input logic w, input logic r, input logic [1:0] sz,
                     input logic us, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic flt, input logic fv,
                     input logic [31:0] fa, input logic bsy);
    drive(w, r, sz, us, a, wd);
    push_exp(n, rd, flt, fv, fa, bsy);
    step();
  endtask

  task automatic count_check(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d cycles, want %0d", n, got, want);
    end else begin
      $display("ok   %s: %0d cycles", n, got);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (bus.read_data !== mon_e.rd || bus.fault !== mon_e.flt ||
          bus.fault_valid !== mon_e.fv || bus.fault_addr !== mon_e.fa ||
          bus.busy !== mon_e.bsy) begin
        errors++;
        $display("FAIL %s: got rd=%h fault=%b fv=%b fa=%h busy=%b, want rd=%h fault=%b fv=%b fa=%h busy=%b",
                 mon_e.name, bus.read_data, bus.fault, bus.fault_valid, bus.fault_addr, bus.busy,
                 mon_e.rd, mon_e.flt, mon_e.fv, mon_e.fa, mon_e.bsy);
      end else begin
        $display("ok   %s: rd=%h fault=%b fv=%b fa=%h busy=%b",
                 mon_e.name, bus.read_data, bus.fault, bus.fault_valid, bus.fault_addr, bus.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, BASE, 32'h0);

    // ---- first clear: one-cycle pulse, then a full sweep ----
    clear = 1'b1;
    step();
    clear = 1'b0;
    txn("reset_state", 0, 1, SZ_WORD, 0, BASE, 0, 32'h0, 0, 0, 32'h0, 1);
    n = 1;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 20) begin
        // word 5 was already swept; this store must be ignored
        drive(1, 1, SZ_WORD, 0, BASE + 32'h14, 32'hCAFE_F00D);
        push_exp("busy_store", 32'h0, 0, 0, 32'h0, 1);
      end else if (n == 30) begin
        drive(0, 1, SZ_WORD, 0, BASE + 32'h2, 32'h0);
        push_exp("busy_misalign_nofault", 32'h0, 0, 0, 32'h0, 1);
      end else begin
        drive(0, 0, SZ_WORD, 0, BASE, 32'h0);
      end
      step();
    end
    count_check("sweep1_len", n, 256);

    txn("rd_first_word", 0, 1, SZ_WORD, 0, BASE,               0, 32'h0, 0, 0, 32'h0, 0);
    txn("rd_last_word",  0, 1, SZ_WORD, 0, BASE + 32'h3FC,     0, 32'h0, 0, 0, 32'h0, 0);
    txn("busy_store_ignored", 0, 1, SZ_WORD, 0, BASE + 32'h14, 0, 32'h0, 0, 0, 32'h0, 0);

    // ---- word store then byte store into lane 1 ----
    txn("st_word_0x10", 1, 0, SZ_WORD, 0, BASE + 32'h10, 32'h1122_3344, 32'h0, 0, 0, 32'h0, 0);
    txn("st_byte_0x11", 1, 0, SZ_BYTE, 0, BASE + 32'h11, 32'h0000_00AB, 32'h0000_0033, 0, 0, 32'h0, 0);
    txn("rd_merged",    0, 1, SZ_WORD, 0, BASE + 32'h10, 0, 32'h1122_AB44, 0, 0, 32'h0, 0);

    // ---- sign / zero extension ----
    txn("st_word_0x20", 1, 0, SZ_WORD, 0, BASE + 32'h20, 32'h80FF_7F01, 32'h0, 0, 0, 32'h0, 0);
    txn("ld_b1_s", 0, 1, SZ_BYTE, 0, BASE + 32'h21, 0, 32'h0000_007F, 0, 0, 32'h0, 0);
    txn("ld_b2_s", 0, 1, SZ_BYTE, 0, BASE + 32'h22, 0, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    txn("ld_b2_u", 0, 1, SZ_BYTE, 1, BASE + 32'h22, 0, 32'h0000_00FF, 0, 0, 32'h0, 0);
    txn("ld_b3_s", 0, 1, SZ_BYTE, 0, BASE + 32'h23, 0, 32'hFFFF_FF80, 0, 0, 32'h0, 0);
    txn("ld_h2_s", 0, 1, SZ_HALF, 0, BASE + 32'h22, 0, 32'hFFFF_80FF, 0, 0, 32'h0, 0);
    txn("ld_h2_u", 0, 1, SZ_HALF, 1, BASE + 32'h22, 0, 32'h0000_80FF, 0, 0, 32'h0, 0);
    txn("ld_h0_s", 0, 1, SZ_HALF, 0, BASE + 32'h20, 0, 32'h0000_7F01, 0, 0, 32'h0, 0);

    // ---- same-cycle load sees old data ----
    txn("st_sees_old", 1, 1, SZ_WORD, 0, BASE + 32'h20, 32'h0000_0055, 32'h80FF_7F01, 0, 0, 32'h0, 0);
    txn("rd_new",      0, 1, SZ_WORD, 0, BASE + 32'h20, 0, 32'h0000_0055, 0, 0, 32'h0, 0);

    // ---- misalignment and first-fault capture ----
    txn("st_misalign", 1, 0, SZ_WORD, 0, BASE + 32'h2, 32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 0);
    txn("misalign_nochange", 0, 1, SZ_WORD, 0, BASE, 0, 32'h0, 0, 1, BASE + 32'h2, 0);
    txn("rd_below_base", 0, 1, SZ_WORD, 0, 32'h0FFF_FFFC, 0, 32'h0, 1, 1, BASE + 32'h2, 0);
    txn("rd_half_odd",   0, 1, SZ_HALF, 0, BASE + 32'h21, 0, 32'h0, 1, 1, BASE + 32'h2, 0);
    txn("rd_rsvd_size",  0, 1, SZ_RSVD, 0, BASE + 32'h20, 0, 32'h0, 1, 1, BASE + 32'h2, 0);
    txn("fault_addr_kept", 0, 0, SZ_WORD, 0, BASE + 32'h20, 0, 32'h0000_0055, 0, 1, BASE + 32'h2, 0);

    // ---- range boundary ----
    txn("st_last_word", 1, 0, SZ_WORD, 0, BASE + 32'h3FC, 32'hDEAD_BEEF, 32'h0, 0, 1, BASE + 32'h2, 0);
    txn("rd_last_word2", 0, 1, SZ_WORD, 0, BASE + 32'h3FC, 0, 32'hDEAD_BEEF, 0, 1, BASE + 32'h2, 0);
    txn("rd_past_end", 0, 1, SZ_WORD, 0, BASE + 32'h400, 0, 32'h0, 1, 1, BASE + 32'h2, 0);
    txn("idle_past_end", 0, 0, SZ_WORD, 0, BASE + 32'h400, 0, 32'h0, 0, 1, BASE + 32'h2, 0);

    // ---- second clear, restarted mid-sweep ----
    drive(0, 0, SZ_WORD, 0, BASE, 32'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    txn("clear_resets_fault", 0, 1, SZ_WORD, 0, BASE + 32'h3FC, 0, 32'h0, 0, 0, 32'h0, 1);
    n = 1;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 100) break;
      step();
    end
    count_check("sweep2_reach_100", n, 100);
    clear = 1'b1;
    step();
    clear = 1'b0;
    txn("midclear_state", 0, 1, SZ_WORD, 0, BASE, 0, 32'h0, 0, 0, 32'h0, 1);
    n = 1;
    drive(0, 0, SZ_WORD, 0, BASE, 32'h0);
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    count_check("sweep3_len", n, 256);

    txn("swept_last",  0, 1, SZ_WORD, 0, BASE + 32'h3FC, 0, 32'h0, 0, 0, 32'h0, 0);
    txn("swept_0x10",  0, 1, SZ_WORD, 0, BASE + 32'h10,  0, 32'h0, 0, 0, 32'h0, 0);
    txn("swept_0x20",  0, 1, SZ_WORD, 0, BASE + 32'h20,  0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 0, SZ_WORD, 0, BASE, 32'h0);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      n++;
      step();
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
